regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 register file and shares it between two writeback requesters: req0 (ALU writeback) and req1 (load/long-latency unit).
- After reset, sequences a zero-fill sweep of the register file, because the regfile array has no reset of its own.
- Then arbitrates writes using a valid/ready handshake and round-robin priority.
- Sits between the writeback sources and the regfile write port; the read ports are not touched.

Parameters:
- AW, 5, register address width.
- DW, 32, data width.
- NREG, 32, number of registers; must equal 2**AW.
- INIT_SWEEP, 1.
  - 1: zero-fill registers 1..NREG-1 after reset.
  - 0: enter RUN directly.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  DW  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- rf_we  out  1  to regfile WE3 (registered).
- rf_addr  out  AW  to regfile A3 (registered).
- rf_wdata  out  DW  to regfile WD3 (registered).
- grant_id  out  1  requester that owns the current rf_* beat (registered).
- init_done  out  1  sweep complete; arbitration active (registered).

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state=INIT (or RUN if INIT_SWEEP=0), sweep cnt=1, rr_ptr=0;
  - rf_we=0, rf_addr=0, rf_wdata=0, grant_id=0;
  - init_done=0 (1 if INIT_SWEEP=0).
- Reset asserted at any point, including mid-sweep or mid-handshake, restarts from this state. Any in-flight rf_* beat is dropped.
- States: INIT, RUN. There are no other states.
- INIT:
  - req0_ready=req1_ready=0.
  - Each cycle registers rf_we=1, rf_addr=cnt, rf_wdata=0, then cnt++.
  - The first cycle after reset release presents addr 1; addr NREG-1 is presented on cycle NREG-1.
  - On the edge that registers addr NREG-1: go to RUN, set init_done=1 the following cycle, set cnt=1.
- RUN arbitration (combinational ready; at most one ready high per cycle):
  - Only one valid: that requester gets ready.
  - Both valid: the requester selected by rr_ptr gets ready.
  - After a grant, rr_ptr = the other requester index. rr_ptr is unchanged when nothing is granted.
- Handshake:
  - Transfer occurs when valid & ready.
  - A requester holds valid, addr and data stable until ready.
  - Valid may deassert only after a transfer.
- Latency:
  - A transfer in cycle N registers rf_we/rf_addr/rf_wdata/grant_id at the end of N, so they are visible in N+1.
  - The regfile captures the write at the end of N+1.
  - Throughput is one write per cycle.
  - rf_we=0 in any cycle following no transfer; rf_addr/rf_wdata hold their previous values.
- Address 0: the request is accepted (ready=1, rr_ptr updates) but rf_we=0 is registered. The write is silently dropped.
- Same-address writes from both requesters in back-to-back cycles land in grant order; the last grant wins.
- No buffering: a requester not granted simply sees ready=0 and retries the next cycle.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins when both are valid, and rr_ptr is unused/removed.
- Undefined: round-robin as above.

Test Plan:
- Sweep: release rst_n with INIT_SWEEP=1.
  - rf_we=1 with rf_addr=1..31 on cycles 1..31, all with rf_wdata=0.
  - init_done=1 on cycle 32.
  - readys stay 0 throughout the sweep.
- Single requester: req0_valid with addr=5, data=0xDEADBEEF in RUN cycle N.
  - req0_ready=1 in N.
  - In N+1: rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF, grant_id=0.
- Contention: both valid continuously for 4 cycles, rr_ptr=0 initially.
  - Grants go req0, req1, req0, req1.
  - grant_id sequence is 0,1,0,1.
  - With REGFILE_ARB_FIXED_PRIO_EN defined: all four grants go to req0.
- Address 0: req1 writes addr=0, data=0x12345678.
  - req1_ready=1.
  - rf_we=0 the next cycle.
  - The next contention grant goes to req0.
- Reset mid-sweep: drop rst_n when rf_addr=10, hold 1 cycle, release.
  - Sweep restarts at addr 1.
  - init_done stays 0 until the full sweep completes.
- Valid during INIT: req0_valid held high from reset release.
  - req0_ready stays 0 through the sweep.
  - req0 is first granted on the cycle init_done goes to 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: zero-fill sweep after reset, then
// valid/ready arbitration of two writeback requesters. REGFILE_ARB_FIXED_PRIO_EN selects fixed req0 priority.
module regfile_write_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int NREG       = 32,
  parameter int INIT_SWEEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          grant_id,
  output logic          init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic          sel1_p0;
  logic          xfer_p0;
  logic [AW-1:0] xfer_addr_p0;
  logic [DW-1:0] xfer_data_p0;
  logic          sweep_last;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic rr_ptr;
`endif

  assign sweep_last = (cnt == AW'(NREG - 1));

  // Stage p0: combinational grant selection and handshake
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    sel1_p0    = req1_valid & ~req0_valid;
`else
    sel1_p0    = req1_valid & (~req0_valid | rr_ptr);
`endif
    case (state)
      INIT: begin
        if (sweep_last) state_nxt = RUN;
      end
      RUN: begin
        // Grants wait for init_done so the first accepted write never overlaps the last sweep beat.
        if (init_done) begin
          req0_ready = req0_valid & ~sel1_p0;
          req1_ready = sel1_p0;
        end
      end
      default: state_nxt = INIT;
    endcase
    xfer_p0      = req0_ready | req1_ready;
    xfer_addr_p0 = sel1_p0 ? req1_addr : req0_addr;
    xfer_data_p0 = sel1_p0 ? req1_data : req0_data;
  end

  // Stage p1: registered regfile write beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= (INIT_SWEEP != 0) ? INIT : RUN;
      cnt       <= AW'(1);
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      grant_id  <= 1'b0;
      init_done <= (INIT_SWEEP == 0);
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      init_done <= (state == RUN);
      case (state)
        INIT: begin
          rf_we    <= 1'b1;
          rf_addr  <= cnt;
          rf_wdata <= '0;
          cnt      <= sweep_last ? AW'(1) : cnt + AW'(1);
        end
        RUN: begin
          // Writes to register 0 are accepted but never reach the array.
          rf_we <= xfer_p0 & (xfer_addr_p0 != '0);
          if (xfer_p0) begin
            rf_addr  <= xfer_addr_p0;
            rf_wdata <= xfer_data_p0;
            grant_id <= sel1_p0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            rr_ptr   <= ~sel1_p0;
`endif
          end
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed sweep/arbitration steps plus random
// traffic against a transaction-level reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        rf_we, grant_id, init_done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  // Reference model state: who has priority next, and the expected write port.
  int          m_prio;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_gid;
  bit          m_known;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .grant_id(grant_id), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_prio = 0;
  endtask

  // Checks sweep beats 1..last; with last=NREG-1 also checks the hand-over to RUN.
  task automatic sweep(input int last);
    for (int k = 1; k <= last; k++) begin
      #1;
      chk("sweep_rdy0", req0_ready, 0);
      chk("sweep_rdy1", req1_ready, 0);
      chk("sweep_init_done", init_done, 0);
      @(posedge clk); #1;
      chk("sweep_we", rf_we, 1);
      chk("sweep_addr", rf_addr, k);
      chk("sweep_wdata", rf_wdata, 0);
      @(negedge clk);
    end
    if (last == 31) begin
      #1;
      chk("sweep_end_rdy0", req0_ready, 0);
      chk("sweep_end_rdy1", req1_ready, 0);
      @(posedge clk); #1;
      chk("init_done_rise", init_done, 1);
      chk("post_sweep_we", rf_we, 0);
      @(negedge clk);
      m_we = 0; m_addr = 5'd31; m_data = 0; m_gid = 0; m_known = 1;
    end
  endtask

  // One RUN cycle: drive, check readys against the model, then check the registered beat.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      output int g);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    if (v0 && v1) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = m_prio;
`endif
    end else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    #1;
    chk("rdy0", req0_ready, (g == 0));
    chk("rdy1", req1_ready, (g == 1));
    if (g >= 0) begin
      m_prio = 1 - g;
      if ((g == 0 ? a0 : a1) != 0) begin
        m_we = 1; m_addr = (g == 0) ? a0 : a1; m_data = (g == 0) ? d0 : d1;
        m_gid = g[0]; m_known = 1;
      end else begin
        m_we = 0; m_known = 0;
      end
    end else m_we = 0;
    @(posedge clk); #1;
    chk("rf_we", rf_we, m_we);
    chk("init_done", init_done, 1);
    if (m_known) begin
      chk("rf_addr", rf_addr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("grant_id", grant_id, m_gid);
    end
    @(negedge clk);
  endtask

  int g;
  int exp_seq[4];
  bit p0, p1;
  logic [4:0]  pa0, pa1;
  logic [31:0] pd0, pd1;

  initial begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    @(negedge clk);
    do_reset();
    sweep(31);

    // Single requester
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, g);
    chk("single_grant", g, 0);
    step(0, 0, 0, 1, 5'd9, 32'h0BADF00D, g);
    step(0, 0, 0, 0, 0, 0, g);

    // Contention for four cycles, priority at req0
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'hA0A0_0000 + i, 1, 5'd4, 32'hB0B0_0000 + i, g);
      chk("contend_gid", grant_id, exp_seq[i]);
    end

    // Address 0 is accepted but dropped
    step(0, 0, 0, 1, 5'd0, 32'h12345678, g);
    chk("addr0_we", rf_we, 0);
    step(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, g);
    chk("after_addr0_grant", grant_id, 0);
    step(0, 0, 0, 0, 0, 0, g);

    // Reset in the middle of the sweep
    do_reset();
    sweep(10);
    do_reset();
    sweep(31);

    // req0 waiting from reset release is served when init_done rises
    req0_valid = 1; req0_addr = 5'd7; req0_data = 32'hC0FFEE00;
    do_reset();
    sweep(31);
    step(1, 5'd7, 32'hC0FFEE00, 0, 0, 0, g);
    chk("init_hold_grant", g, 0);

    // Random traffic obeying the hold-until-ready rule
    p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; pa0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; pa1 = 5'($urandom_range(0, 31)); pd1 = $urandom;
      end
      step(p0, pa0, pd0, p1, pa1, pd1, g);
      if (g == 0) p0 = 0;
      else if (g == 1) p1 = 0;
    end
    step(0, 0, 0, 0, 0, 0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
